// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM slave: command codes, FSM states and a
// ceiling-log2 helper used to size counters and memory indices.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RX   = 2'b01,
        EXEC = 2'b10,
        TX   = 2'b11
    } state_e;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port word memory: synchronous write, registered read. Addresses at or
// beyond MEM_DEPTH never write and read back as zero.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? clog2(MEM_DEPTH) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = AW1'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  in_range_s;
    logic [IDX_W-1:0]      idx_s;

    assign in_range_s = ({1'b0, addr} < DEPTH_C);
    assign idx_s      = addr[IDX_W-1:0];
    assign rdata      = rdata_r;

    // Array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we && in_range_s) begin
            mem_r[idx_s] <= wdata;
        end
    end

    // Registered read port, zero for out-of-range addresses
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (in_range_s) begin
            rdata_r <= mem_r[idx_s];
        end else begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/spi_ram_slave_p.sv
// SPI slave front end: deserialises {cmd, payload} frames from MOSI while SS_n
// is low and executes them against spi_ram_mem, serialising reads on MISO.
module spi_ram_slave_p
    import spi_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic busy,
    output logic err
);

    localparam int FRAME_W = 2 + DATA_WIDTH;
    localparam int CNT_W   = clog2(FRAME_W);
    localparam int AW1     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      RX_LAST_C  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]      TX_LAST_C  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   DEPTH_C    = AW1'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   LAST_C     = DEPTH_C - {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [FRAME_W-1:0]      frame_r;
    logic [DATA_WIDTH-1:0]   tx_shift_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r, rd_addr_r;
    logic                    err_r, miso_r, busy_r;

    logic [1:0]              cmd_s;
    logic [DATA_WIDTH-1:0]   payload_s, mem_rdata_s, rd_word_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic                    wr_sel_s, mem_we_s, wr_in_range_s, rd_in_range_s;
    logic                    last_rx_s, last_tx_s;

    // Post-increment with wrap; an out-of-range address also wraps to zero
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        if ({1'b0, a} >= LAST_C) begin
            return {ADDR_WIDTH{1'b0}};
        end else begin
            return a + ADDR_ONE_C;
        end
    endfunction

    assign cmd_s         = frame_r[FRAME_W-1 -: 2];
    assign payload_s     = frame_r[DATA_WIDTH-1:0];
    assign wr_in_range_s = ({1'b0, wr_addr_r} < DEPTH_C);
    assign rd_in_range_s = ({1'b0, rd_addr_r} < DEPTH_C);
    assign last_rx_s     = (cnt_r == RX_LAST_C);
    assign last_tx_s     = (cnt_r == TX_LAST_C);
    assign wr_sel_s      = (state_r == EXEC) && (cmd_s == CMD_WR_DATA);
    assign mem_we_s      = wr_sel_s && wr_in_range_s;
    // The read port tracks rd_addr all frame long, so data is ready by EXEC
    assign mem_addr_s    = wr_sel_s ? wr_addr_r : rd_addr_r;
    assign rd_word_s     = rd_in_range_s ? mem_rdata_s : {DATA_WIDTH{1'b0}};

    assign MISO = miso_r;
    assign busy = busy_r;
    assign err  = err_r;

    spi_ram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (payload_s),
        .rdata (mem_rdata_s)
    );

    // State register and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!SS_n) state_nxt_s = RX;
                else       state_nxt_s = IDLE;
            end
            RX: begin
                if (SS_n)           state_nxt_s = IDLE;
                else if (last_rx_s) state_nxt_s = EXEC;
                else                state_nxt_s = RX;
            end
            EXEC: begin
                if (SS_n)                     state_nxt_s = IDLE;
                else if (cmd_s == CMD_RD_DATA) state_nxt_s = TX;
                else                          state_nxt_s = RX;
            end
            TX: begin
                if (SS_n)           state_nxt_s = IDLE;
                else if (last_tx_s) state_nxt_s = RX;
                else                state_nxt_s = TX;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Frame shifting, bit counting, command commit and MISO serialisation
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            frame_r    <= {FRAME_W{1'b0}};
            tx_shift_r <= {DATA_WIDTH{1'b0}};
            wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            rd_addr_r  <= {ADDR_WIDTH{1'b0}};
            err_r      <= 1'b0;
            miso_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    miso_r <= 1'b0;
                    if (!SS_n) begin
                        frame_r <= {frame_r[FRAME_W-2:0], MOSI};
                        cnt_r   <= CNT_ONE_C;
                    end else begin
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                RX: begin
                    miso_r <= 1'b0;
                    if (SS_n) begin
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        frame_r <= {frame_r[FRAME_W-2:0], MOSI};
                        cnt_r   <= last_rx_s ? {CNT_W{1'b0}} : cnt_r + CNT_ONE_C;
                    end
                end
                EXEC: begin
                    cnt_r  <= {CNT_W{1'b0}};
                    miso_r <= 1'b0;
                    case (cmd_s)
                        CMD_WR_ADDR: wr_addr_r <= payload_s[ADDR_WIDTH-1:0];
                        CMD_WR_DATA: begin
                            if (!wr_in_range_s) err_r <= 1'b1;
                            if (AUTO_INC != 0) wr_addr_r <= next_addr(wr_addr_r);
                        end
                        CMD_RD_ADDR: rd_addr_r <= payload_s[ADDR_WIDTH-1:0];
                        CMD_RD_DATA: begin
                            if (!rd_in_range_s) err_r <= 1'b1;
                            if (AUTO_INC != 0) rd_addr_r <= next_addr(rd_addr_r);
                            tx_shift_r <= {rd_word_s[DATA_WIDTH-2:0], 1'b0};
                            miso_r     <= ~SS_n & rd_word_s[DATA_WIDTH-1];
                        end
                        default: miso_r <= 1'b0;
                    endcase
                end
                TX: begin
                    if (SS_n || last_tx_s) begin
                        miso_r <= 1'b0;
                        cnt_r  <= {CNT_W{1'b0}};
                    end else begin
                        miso_r     <= tx_shift_r[DATA_WIDTH-1];
                        tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                        cnt_r      <= cnt_r + CNT_ONE_C;
                    end
                end
                default: begin
                    miso_r <= 1'b0;
                    cnt_r  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Self-checking bench: three instances (defaults, no auto-increment, 200-word
// memory) driven by directed scenarios and random frames against a word model.
module tb_spi_ram_slave_p;

    logic       clk = 1'b0;
    logic [2:0] rst_v  = 3'b111;
    logic [2:0] mosi_v = 3'b000;
    logic [2:0] ss_v   = 3'b111;
    wire  [2:0] miso_v, busy_v, err_v;

    int n_pass  = 0;
    int n_total = 0;

    // reference model state, one slot per instance
    logic [7:0] m_mem [3][256];
    int         m_wa [3];
    int         m_ra [3];
    logic       m_err [3];
    int         depth [3] = '{256, 256, 200};
    int         ainc  [3] = '{1, 0, 1};
    logic       exec_miso;

    always #5 clk = ~clk;

    spi_ram_slave_p u0 (.clk(clk), .rst(rst_v[0]), .MOSI(mosi_v[0]), .SS_n(ss_v[0]),
                        .MISO(miso_v[0]), .busy(busy_v[0]), .err(err_v[0]));
    spi_ram_slave_p #(.AUTO_INC(0)) u1 (.clk(clk), .rst(rst_v[1]), .MOSI(mosi_v[1]), .SS_n(ss_v[1]),
                        .MISO(miso_v[1]), .busy(busy_v[1]), .err(err_v[1]));
    spi_ram_slave_p #(.MEM_DEPTH(200)) u2 (.clk(clk), .rst(rst_v[2]), .MOSI(mosi_v[2]), .SS_n(ss_v[2]),
                        .MISO(miso_v[2]), .busy(busy_v[2]), .err(err_v[2]));

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset(input int d);
        m_wa[d] = 0; m_ra[d] = 0; m_err[d] = 1'b0;
    endtask

    task automatic model_frame(input int d, input logic [1:0] cmd, input logic [7:0] pl,
                               output logic [7:0] exp);
        exp = 8'h00;
        case (cmd)
            2'b00: m_wa[d] = int'(pl);
            2'b01: begin
                if (m_wa[d] < depth[d]) m_mem[d][m_wa[d]] = pl;
                else m_err[d] = 1'b1;
                if (ainc[d] != 0) m_wa[d] = (m_wa[d] + 1 >= depth[d]) ? 0 : m_wa[d] + 1;
            end
            2'b10: m_ra[d] = int'(pl);
            default: begin
                if (m_ra[d] < depth[d]) exp = m_mem[d][m_ra[d]];
                else m_err[d] = 1'b1;
                if (ainc[d] != 0) m_ra[d] = (m_ra[d] + 1 >= depth[d]) ? 0 : m_ra[d] + 1;
            end
        endcase
    endtask

    task automatic drive_bits(input int d, input logic [1:0] cmd, input logic [7:0] pl, input int nbits);
        logic [9:0] f;
        f = {cmd, pl};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ss_v[d]   = 1'b0;
            mosi_v[d] = f[9-i];
        end
    endtask

    // full frame + EXEC cycle; for reads also samples tx_bits MISO bits
    task automatic xfer(input int d, input logic [1:0] cmd, input logic [7:0] pl, input int tx_bits,
                        output logic [7:0] rd, output logic [7:0] exp);
        drive_bits(d, cmd, pl, 10);
        model_frame(d, cmd, pl, exp);
        rd = 8'h00;
        @(negedge clk);
        exec_miso = miso_v[d];
        mosi_v[d] = 1'($urandom);
        if (cmd == 2'b11) begin
            for (int i = 0; i < tx_bits; i++) begin
                @(negedge clk);
                rd[7-i]   = miso_v[d];
                mosi_v[d] = 1'($urandom);
                if (i == tx_bits - 1 && tx_bits < 8) ss_v[d] = 1'b1;
            end
        end
    endtask

    task automatic end_window(input int d);
        @(negedge clk);
        ss_v[d] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_v = 3'b111; ss_v = 3'b111;
        @(negedge clk); @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            model_reset(d);
            n_total++; if (miso_v[d] !== 1'b0) $display("FAIL reset_miso[%0d]: got %b want 0", d, miso_v[d]); else n_pass++;
            n_total++; if (busy_v[d] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", d, busy_v[d]); else n_pass++;
            n_total++; if (err_v[d] !== 1'b0) $display("FAIL reset_err[%0d]: got %b want 0", d, err_v[d]); else n_pass++;
        end
        rst_v = 3'b000;
    endtask

    task automatic test_basic();
        logic [7:0] rd, e;
        xfer(0, 2'b00, 8'h10, 8, rd, e);
        xfer(0, 2'b01, 8'hA5, 8, rd, e);
        xfer(0, 2'b10, 8'h10, 8, rd, e);
        xfer(0, 2'b11, 8'h00, 8, rd, e);
        n_total++; if (exec_miso !== 1'b0) $display("FAIL basic_exec_miso: got %b want 0", exec_miso); else n_pass++;
        n_total++; if (rd !== 8'hA5) $display("FAIL basic_read: got %h want a5", rd); else n_pass++;
        n_total++; if (busy_v[0] !== 1'b1) $display("FAIL basic_busy_in_window: got %b want 1", busy_v[0]); else n_pass++;
        end_window(0);
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL basic_busy_idle: got %b want 0", busy_v[0]); else n_pass++;
        n_total++; if (err_v[0] !== 1'b0) $display("FAIL basic_err: got %b want 0", err_v[0]); else n_pass++;
    endtask

    task automatic test_autoinc_wrap();
        logic [7:0] rd, r1, e;
        xfer(0, 2'b00, 8'hFF, 8, rd, e);
        xfer(0, 2'b01, 8'h11, 8, rd, e);
        xfer(0, 2'b01, 8'h22, 8, rd, e);
        xfer(0, 2'b10, 8'hFF, 8, rd, e);
        xfer(0, 2'b11, 8'h00, 8, r1, e);
        xfer(0, 2'b11, 8'h00, 8, rd, e);
        end_window(0);
        n_total++; if (r1 !== 8'h11) $display("FAIL wrap_rd_ff: got %h want 11", r1); else n_pass++;
        n_total++; if (rd !== 8'h22) $display("FAIL wrap_rd_00: got %h want 22", rd); else n_pass++;
    endtask

    task automatic test_no_inc();
        logic [7:0] rd, r1, r2, e;
        xfer(1, 2'b00, 8'h06, 8, rd, e);
        xfer(1, 2'b01, 8'h5A, 8, rd, e);
        xfer(1, 2'b00, 8'h05, 8, rd, e);
        xfer(1, 2'b01, 8'h33, 8, rd, e);
        xfer(1, 2'b01, 8'h44, 8, rd, e);
        xfer(1, 2'b10, 8'h05, 8, rd, e);
        xfer(1, 2'b11, 8'h00, 8, r1, e);
        xfer(1, 2'b11, 8'h00, 8, r2, e);
        xfer(1, 2'b10, 8'h06, 8, rd, e);
        xfer(1, 2'b11, 8'h00, 8, rd, e);
        end_window(1);
        n_total++; if (r1 !== 8'h44) $display("FAIL noinc_rd05: got %h want 44", r1); else n_pass++;
        n_total++; if (r2 !== 8'h44) $display("FAIL noinc_rd05_hold: got %h want 44", r2); else n_pass++;
        n_total++; if (rd !== 8'h5A) $display("FAIL noinc_rd06: got %h want 5a", rd); else n_pass++;
    endtask

    task automatic test_abort();
        logic [7:0] rd, e;
        xfer(0, 2'b00, 8'h03, 8, rd, e);
        xfer(0, 2'b01, 8'h3C, 8, rd, e);
        end_window(0);
        xfer(0, 2'b00, 8'h03, 8, rd, e);
        drive_bits(0, 2'b01, 8'h77, 6);
        @(negedge clk);
        n_total++; if (busy_v[0] !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy_v[0]); else n_pass++;
        ss_v[0] = 1'b1;
        @(negedge clk);
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL abort_busy_after: got %b want 0", busy_v[0]); else n_pass++;
        xfer(0, 2'b10, 8'h03, 8, rd, e);
        xfer(0, 2'b11, 8'h00, 8, rd, e);
        end_window(0);
        n_total++; if (rd !== 8'h3C) $display("FAIL abort_mem03: got %h want 3c", rd); else n_pass++;
        n_total++; if (err_v[0] !== 1'b0) $display("FAIL abort_err: got %b want 0", err_v[0]); else n_pass++;
    endtask

    task automatic test_oor();
        logic [7:0] rd, r1, r2, r3, e;
        xfer(2, 2'b00, 8'hC7, 8, rd, e);
        xfer(2, 2'b01, 8'h12, 8, rd, e);
        xfer(2, 2'b01, 8'h34, 8, rd, e);
        xfer(2, 2'b00, 8'hC8, 8, rd, e);
        xfer(2, 2'b01, 8'h99, 8, rd, e);
        end_window(2);
        n_total++; if (err_v[2] !== 1'b1) $display("FAIL oor_err_set: got %b want 1", err_v[2]); else n_pass++;
        xfer(2, 2'b10, 8'hC7, 8, rd, e);
        xfer(2, 2'b11, 8'h00, 8, r1, e);
        xfer(2, 2'b11, 8'h00, 8, r2, e);
        xfer(2, 2'b10, 8'hC8, 8, rd, e);
        xfer(2, 2'b11, 8'h00, 8, r3, e);
        xfer(2, 2'b11, 8'h00, 8, rd, e);
        end_window(2);
        n_total++; if (r1 !== 8'h12) $display("FAIL oor_rd_c7: got %h want 12", r1); else n_pass++;
        n_total++; if (r2 !== 8'h34) $display("FAIL oor_wrap_rd_00: got %h want 34", r2); else n_pass++;
        n_total++; if (r3 !== 8'h00) $display("FAIL oor_rd_c8: got %h want 00", r3); else n_pass++;
        n_total++; if (rd !== 8'h34) $display("FAIL oor_rd_after_wrap: got %h want 34", rd); else n_pass++;
        n_total++; if (err_v[2] !== 1'b1) $display("FAIL oor_err_sticky: got %b want 1", err_v[2]); else n_pass++;
        @(negedge clk); rst_v[2] = 1'b1;
        @(negedge clk); rst_v[2] = 1'b0;
        model_reset(2);
        n_total++; if (err_v[2] !== 1'b0) $display("FAIL oor_err_cleared: got %b want 0", err_v[2]); else n_pass++;
        n_total++; if (miso_v[2] !== 1'b0) $display("FAIL oor_rst_miso: got %b want 0", miso_v[2]); else n_pass++;
        n_total++; if (busy_v[2] !== 1'b0) $display("FAIL oor_rst_busy: got %b want 0", busy_v[2]); else n_pass++;
    endtask

    task automatic test_rst_during_tx();
        logic [7:0] rd, r1, e;
        xfer(0, 2'b00, 8'h40, 8, rd, e);
        xfer(0, 2'b01, 8'hC3, 8, rd, e);
        xfer(0, 2'b10, 8'h40, 8, rd, e);
        drive_bits(0, 2'b11, 8'h00, 10);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_total++; if (miso_v[0] !== 1'b1) $display("FAIL rsttx_bit6: got %b want 1", miso_v[0]); else n_pass++;
            end
        end
        rst_v[0] = 1'b1;
        ss_v[0]  = 1'b1;
        @(negedge clk);
        n_total++; if (miso_v[0] !== 1'b0) $display("FAIL rsttx_miso: got %b want 0", miso_v[0]); else n_pass++;
        n_total++; if (busy_v[0] !== 1'b0) $display("FAIL rsttx_busy: got %b want 0", busy_v[0]); else n_pass++;
        rst_v[0] = 1'b0;
        model_reset(0);
        xfer(0, 2'b11, 8'h00, 8, r1, e);
        xfer(0, 2'b10, 8'h40, 8, rd, e);
        xfer(0, 2'b11, 8'h00, 8, rd, e);
        end_window(0);
        n_total++; if (r1 !== 8'h22) $display("FAIL rsttx_rd_addr0: got %h want 22", r1); else n_pass++;
        n_total++; if (rd !== 8'hC3) $display("FAIL rsttx_mem_kept: got %h want c3", rd); else n_pass++;
    endtask

    task automatic test_random(input int d);
        logic [7:0] rd, e, pl;
        logic [1:0] cmd;
        int nfr, txb, sh;
        // known contents everywhere so every read has a model value
        for (int a = 0; a < depth[d]; a++) begin
            xfer(d, 2'b00, 8'(a), 8, rd, e);
            xfer(d, 2'b01, 8'($urandom), 8, rd, e);
        end
        end_window(d);
        for (int w = 0; w < 15; w++) begin
            nfr = int'($urandom_range(1, 5));
            for (int f = 0; f < nfr; f++) begin
                cmd = 2'($urandom);
                pl  = 8'($urandom);
                if (f == nfr - 1 && $urandom_range(0, 3) == 0) begin
                    if (cmd == 2'b11) begin
                        txb = int'($urandom_range(1, 7));
                        xfer(d, cmd, pl, txb, rd, e);
                        sh = 8 - txb;
                        n_total++;
                        if ((rd >> sh) !== (e >> sh))
                            $display("FAIL rand%0d_txabort: got %h want %h (%0d bits)", d, rd >> sh, e >> sh, txb);
                        else n_pass++;
                    end else begin
                        drive_bits(d, cmd, pl, int'($urandom_range(1, 9)));
                    end
                end else begin
                    xfer(d, cmd, pl, 8, rd, e);
                    if (cmd == 2'b11) begin
                        n_total++;
                        if (rd !== e) $display("FAIL rand%0d_read: got %h want %h", d, rd, e);
                        else n_pass++;
                    end
                end
            end
            end_window(d);
            n_total++; if (busy_v[d] !== 1'b0) $display("FAIL rand%0d_busy: got %b want 0", d, busy_v[d]); else n_pass++;
            n_total++; if (err_v[d] !== m_err[d]) $display("FAIL rand%0d_err: got %b want %b", d, err_v[d], m_err[d]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_autoinc_wrap();
        test_no_inc();
        test_abort();
        test_oor();
        test_rst_during_tx();
        test_random(0);
        test_random(1);
        test_random(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
